// File: rtl/product_serializer.sv
// rtl/product_serializer.sv - serializes a 320-bit product into WORD_W words, least-significant word first.
// Optional macro PROD_SERIAL_PARITY_EN adds out_parity, the even parity of out_data.
module product_serializer #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [319:0]      p_in,
  input  logic              p_valid,
  output logic              p_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy
`ifdef PROD_SERIAL_PARITY_EN
  ,
  output logic              out_parity
`endif
);

  localparam int         NWORDS   = 320 / WORD_W;
  localparam logic [3:0] LAST_IDX = 4'(NWORDS - 1);

  if (WORD_W != 32 && WORD_W != 64) begin : g_bad_width
    $error("product_serializer: WORD_W must be 32 or 64");
  end

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic [319:0]      hold_q, hold_d;
  logic [8:0]        word_base;
  logic [WORD_W-1:0] cur_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (p_valid) begin
          hold_d  = p_in;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        // p_in/p_valid are deliberately not looked at here; hold stays frozen
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Every output is decoded from registered state only
  always_comb begin
    word_base = 9'(idx_q) * 9'(WORD_W);
    cur_word  = hold_q[word_base +: WORD_W];
    p_ready   = (state_q == IDLE);
    out_valid = (state_q == SEND);
    busy      = (state_q == SEND);
    out_data  = out_valid ? cur_word : '0;
    out_last  = out_valid && (idx_q == LAST_IDX);
`ifdef PROD_SERIAL_PARITY_EN
    out_parity = ^out_data;
`endif
  end

endmodule
